// File: rtl/alarm_bank_ctrl.sv
// alarm_bank_ctrl: bank of NUM_ALARMS alarm slots with button-driven editing,
// minute-tick matching, snooze and ring auto-dismiss.
// Handshake note: there are no valid/ready channels here; every btn_* input and
// min_tick is a single-cycle pulse that is acted on in the cycle it is high.
module alarm_bank_ctrl #(
  parameter int NUM_ALARMS        = 4,
  parameter int SNOOZE_MINS       = 9,
  parameter int RING_TIMEOUT_MINS = 5,
  localparam int IW = (NUM_ALARMS > 2) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  btn_set,
  input  logic                  btn_sel,
  input  logic                  btn_inc_hours,
  input  logic                  btn_inc_mins,
  input  logic                  btn_toggle_en,
  input  logic                  btn_snooze,
  input  logic                  btn_dismiss,
  input  logic [7:0]            current_hours,
  input  logic [7:0]            current_mins,
  input  logic                  min_tick,
  output logic [IW-1:0]         sel_index,
  output logic [7:0]            alarm_hours,
  output logic [7:0]            alarm_mins,
  output logic [NUM_ALARMS-1:0] alarm_enabled,
  output logic                  editing,
  output logic                  alarm_ringing,
  output logic                  alarm_snoozed,
  output logic [IW-1:0]         ring_index
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SET_HOURS = 3'd1,
    SET_MINS  = 3'd2,
    RINGING   = 3'd3,
    SNOOZED   = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           sel_q, sel_d;
  logic [IW-1:0]           ring_idx_q, ring_idx_d;
  logic [7:0]              hours_q [NUM_ALARMS];
  logic [7:0]              hours_d [NUM_ALARMS];
  logic [7:0]              mins_q  [NUM_ALARMS];
  logic [7:0]              mins_d  [NUM_ALARMS];
  logic [NUM_ALARMS-1:0]   en_q, en_d;
  logic [7:0]              snz_h_q, snz_h_d;
  logic [7:0]              snz_m_q, snz_m_d;
  logic [5:0]              ring_cnt_q, ring_cnt_d;

  logic                    match_any;
  logic [IW-1:0]           match_idx;
  logic [7:0]              tgt_h;
  logic [7:0]              tgt_m;
  logic [7:0]              sum_m;
  logic [5:0]              cnt_inc;

  // Find the lowest enabled slot whose time equals the current time.
  always_comb begin
    match_any = 1'b0;
    match_idx = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (en_q[i] && (hours_q[i] == current_hours) && (mins_q[i] == current_mins)) begin
        match_any = 1'b1;
        match_idx = IW'(i);
      end
    end
  end

  // Snooze target: current time plus SNOOZE_MINS, carrying into hours and wrapping at 24h.
  always_comb begin
    sum_m = current_mins + 8'(SNOOZE_MINS);
    tgt_h = current_hours;
    tgt_m = sum_m;
    if (sum_m >= 8'd60) begin
      tgt_m = sum_m - 8'd60;
      tgt_h = current_hours + 8'd1;
    end
    if (tgt_h >= 8'd24) tgt_h = 8'd0;
  end

  // Next-state and datapath updates; every register holds unless a case below changes it.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    ring_idx_d = ring_idx_q;
    hours_d    = hours_q;
    mins_d     = mins_q;
    en_d       = en_q;
    snz_h_d    = snz_h_q;
    snz_m_d    = snz_m_q;
    ring_cnt_d = ring_cnt_q;
    cnt_inc    = ring_cnt_q + 6'd1;

    case (state_q)
      IDLE: begin
        // A due alarm takes precedence over entering edit mode.
        if (min_tick && match_any) begin
          state_d    = RINGING;
          ring_idx_d = match_idx;
          ring_cnt_d = '0;
        end else if (btn_set) begin
          state_d = SET_HOURS;
        end
        if (btn_toggle_en) en_d[sel_q] = ~en_q[sel_q];
        if (btn_sel) sel_d = (sel_q == IW'(NUM_ALARMS - 1)) ? '0 : sel_q + 1'b1;
      end
      SET_HOURS: begin
        if (btn_inc_hours) begin
          hours_d[sel_q] = (hours_q[sel_q] >= 8'd23) ? 8'd0 : hours_q[sel_q] + 8'd1;
        end else if (btn_set) begin
          state_d = SET_MINS;
        end
      end
      SET_MINS: begin
        if (btn_inc_mins) begin
          mins_d[sel_q] = (mins_q[sel_q] >= 8'd59) ? 8'd0 : mins_q[sel_q] + 8'd1;
        end else if (btn_set) begin
          state_d     = IDLE;
          en_d[sel_q] = 1'b1;
        end
      end
      RINGING: begin
        if (btn_dismiss) begin
          state_d = IDLE;
        end else if (btn_snooze) begin
          state_d = SNOOZED;
          snz_h_d = tgt_h;
          snz_m_d = tgt_m;
        end else if (min_tick) begin
          ring_cnt_d = cnt_inc;
          if (cnt_inc >= 6'(RING_TIMEOUT_MINS)) state_d = IDLE;
        end
      end
      SNOOZED: begin
        if (btn_dismiss) begin
          state_d = IDLE;
        end else if (min_tick) begin
          if (match_any) begin
            state_d    = RINGING;
            ring_idx_d = match_idx;
            ring_cnt_d = '0;
          end else if ((current_hours == snz_h_q) && (current_mins == snz_m_q)) begin
            state_d    = RINGING;
            ring_cnt_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and storage registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      ring_idx_q <= '0;
      en_q       <= '0;
      snz_h_q    <= '0;
      snz_m_q    <= '0;
      ring_cnt_q <= '0;
      for (int i = 0; i < NUM_ALARMS; i++) begin
        hours_q[i] <= '0;
        mins_q[i]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      ring_idx_q <= ring_idx_d;
      en_q       <= en_d;
      snz_h_q    <= snz_h_d;
      snz_m_q    <= snz_m_d;
      ring_cnt_q <= ring_cnt_d;
      hours_q    <= hours_d;
      mins_q     <= mins_d;
    end
  end

  // Outputs decode directly from registered state; slot view follows sel_index.
  always_comb begin
    sel_index     = sel_q;
    ring_index    = ring_idx_q;
    alarm_hours   = hours_q[sel_q];
    alarm_mins    = mins_q[sel_q];
    alarm_enabled = en_q;
    editing       = (state_q == SET_HOURS) || (state_q == SET_MINS);
    alarm_ringing = (state_q == RINGING);
    alarm_snoozed = (state_q == SNOOZED);
  end

endmodule

// File: tb/tb_alarm_bank_ctrl.sv
// tb_alarm_bank_ctrl: directed scenarios for alarm_bank_ctrl with hand-computed expectations.
module tb_alarm_bank_ctrl;

  localparam int NA = 4;
  localparam int IW = 2;

  localparam logic [6:0] B_SET = 7'd1;
  localparam logic [6:0] B_SEL = 7'd2;
  localparam logic [6:0] B_HR  = 7'd4;
  localparam logic [6:0] B_MIN = 7'd8;
  localparam logic [6:0] B_TOG = 7'd16;
  localparam logic [6:0] B_SNZ = 7'd32;
  localparam logic [6:0] B_DIS = 7'd64;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          btn_set = 1'b0, btn_sel = 1'b0, btn_inc_hours = 1'b0, btn_inc_mins = 1'b0;
  logic          btn_toggle_en = 1'b0, btn_snooze = 1'b0, btn_dismiss = 1'b0;
  logic [7:0]    current_hours = 8'd0, current_mins = 8'd0;
  logic          min_tick = 1'b0;
  logic [IW-1:0] sel_index, ring_index;
  logic [7:0]    alarm_hours, alarm_mins;
  logic [NA-1:0] alarm_enabled;
  logic          editing, alarm_ringing, alarm_snoozed;

  int checks = 0;
  int errors = 0;

  alarm_bank_ctrl #(.NUM_ALARMS(NA), .SNOOZE_MINS(9), .RING_TIMEOUT_MINS(5)) dut (
    .clk(clk), .reset(reset),
    .btn_set(btn_set), .btn_sel(btn_sel), .btn_inc_hours(btn_inc_hours),
    .btn_inc_mins(btn_inc_mins), .btn_toggle_en(btn_toggle_en),
    .btn_snooze(btn_snooze), .btn_dismiss(btn_dismiss),
    .current_hours(current_hours), .current_mins(current_mins), .min_tick(min_tick),
    .sel_index(sel_index), .alarm_hours(alarm_hours), .alarm_mins(alarm_mins),
    .alarm_enabled(alarm_enabled), .editing(editing), .alarm_ringing(alarm_ringing),
    .alarm_snoozed(alarm_snoozed), .ring_index(ring_index)
  );

  // Clock
  always #5 clk = ~clk;

  // Drive a button combination for one cycle, n times; returns at a falling edge.
  task automatic press(input logic [6:0] b, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      btn_set = b[0]; btn_sel = b[1]; btn_inc_hours = b[2]; btn_inc_mins = b[3];
      btn_toggle_en = b[4]; btn_snooze = b[5]; btn_dismiss = b[6];
      @(negedge clk);
      btn_set = 0; btn_sel = 0; btn_inc_hours = 0; btn_inc_mins = 0;
      btn_toggle_en = 0; btn_snooze = 0; btn_dismiss = 0;
    end
  endtask

  // One-cycle min_tick with the given current time.
  task automatic tick(input logic [7:0] h, input logic [7:0] m);
    @(negedge clk);
    current_hours = h; current_mins = m; min_tick = 1'b1;
    @(negedge clk);
    min_tick = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (sel_index !== 2'd0) begin errors++; $display("FAIL rst_sel got %0d want 0", sel_index); end
    checks++; if (alarm_enabled !== 4'b0000) begin errors++; $display("FAIL rst_en got %b want 0000", alarm_enabled); end
    checks++; if ({alarm_hours, alarm_mins} !== 16'd0) begin errors++; $display("FAIL rst_time got %0d:%0d want 0:0", alarm_hours, alarm_mins); end
    checks++; if ({editing, alarm_ringing, alarm_snoozed} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b want 000", {editing, alarm_ringing, alarm_snoozed}); end
    checks++; if (ring_index !== 2'd0) begin errors++; $display("FAIL rst_ridx got %0d want 0", ring_index); end
  endtask

  task automatic test_set_and_ring();
    press(B_SEL, 2);
    checks++; if (sel_index !== 2'd2) begin errors++; $display("FAIL sel2 got %0d want 2", sel_index); end
    press(B_SET, 1);
    checks++; if (editing !== 1'b1) begin errors++; $display("FAIL edit_on got %0b want 1", editing); end
    press(B_HR, 6); press(B_SET, 1); press(B_MIN, 30);
    checks++; if ({alarm_hours, alarm_mins} !== {8'd6, 8'd30}) begin errors++; $display("FAIL set_0630 got %0d:%0d want 6:30", alarm_hours, alarm_mins); end
    press(B_SET, 1);
    checks++; if (editing !== 1'b0) begin errors++; $display("FAIL edit_off got %0b want 0", editing); end
    checks++; if (alarm_enabled !== 4'b0100) begin errors++; $display("FAIL en_slot2 got %b want 0100", alarm_enabled); end
    tick(8'd6, 8'd30);
    checks++; if (alarm_ringing !== 1'b1 || ring_index !== 2'd2) begin errors++; $display("FAIL ring_0630 got ring=%0b idx=%0d want ring=1 idx=2", alarm_ringing, ring_index); end
    press(B_DIS, 1);
    checks++; if (alarm_ringing !== 1'b0 || alarm_hours !== 8'd6) begin errors++; $display("FAIL dismiss got ring=%0b hrs=%0d want ring=0 hrs=6", alarm_ringing, alarm_hours); end
  endtask

  task automatic test_lowest_index();
    press(B_SEL, 2);
    checks++; if (sel_index !== 2'd0) begin errors++; $display("FAIL sel_wrap got %0d want 0", sel_index); end
    press(B_SET, 1); press(B_HR, 7); press(B_SET, 2);
    press(B_SEL, 3); press(B_SET, 1); press(B_HR, 7); press(B_SET, 2);
    checks++; if (alarm_enabled !== 4'b1101) begin errors++; $display("FAIL en_0_3 got %b want 1101", alarm_enabled); end
    tick(8'd7, 8'd0);
    checks++; if (alarm_ringing !== 1'b1 || ring_index !== 2'd0) begin errors++; $display("FAIL ring_low got ring=%0b idx=%0d want ring=1 idx=0", alarm_ringing, ring_index); end
    press(B_DIS, 1);
  endtask

  task automatic test_snooze();
    press(B_SEL, 2); press(B_SET, 1); press(B_HR, 23); press(B_SET, 1); press(B_MIN, 55); press(B_SET, 1);
    tick(8'd23, 8'd55);
    checks++; if (alarm_ringing !== 1'b1 || ring_index !== 2'd1) begin errors++; $display("FAIL ring_2355 got ring=%0b idx=%0d want ring=1 idx=1", alarm_ringing, ring_index); end
    press(B_SNZ, 1);
    checks++; if (alarm_snoozed !== 1'b1 || alarm_ringing !== 1'b0) begin errors++; $display("FAIL snoozed got snz=%0b ring=%0b want snz=1 ring=0", alarm_snoozed, alarm_ringing); end
    tick(8'd0, 8'd3);
    checks++; if (alarm_snoozed !== 1'b1) begin errors++; $display("FAIL snz_early got %0b want 1", alarm_snoozed); end
    tick(8'd0, 8'd4);
    checks++; if (alarm_ringing !== 1'b1 || ring_index !== 2'd1 || alarm_snoozed !== 1'b0) begin errors++; $display("FAIL snz_ring got ring=%0b idx=%0d snz=%0b want 1 1 0", alarm_ringing, ring_index, alarm_snoozed); end
    press(B_SNZ | B_DIS, 1);
    checks++; if (alarm_ringing !== 1'b0 || alarm_snoozed !== 1'b0) begin errors++; $display("FAIL dis_wins got ring=%0b snz=%0b want 0 0", alarm_ringing, alarm_snoozed); end
    // A slot match while snoozed rings that slot instead.
    tick(8'd23, 8'd55); press(B_SNZ, 1); tick(8'd6, 8'd30);
    checks++; if (alarm_ringing !== 1'b1 || ring_index !== 2'd2) begin errors++; $display("FAIL snz_cancel got ring=%0b idx=%0d want 1 2", alarm_ringing, ring_index); end
    press(B_DIS, 1);
  endtask

  task automatic test_timeout();
    tick(8'd6, 8'd30);
    for (int k = 31; k <= 34; k++) tick(8'd6, 8'(k));
    checks++; if (alarm_ringing !== 1'b1) begin errors++; $display("FAIL to_4th got %0b want 1", alarm_ringing); end
    tick(8'd6, 8'd35);
    checks++; if (alarm_ringing !== 1'b0) begin errors++; $display("FAIL to_5th got %0b want 0", alarm_ringing); end
    checks++; if ({alarm_hours, alarm_mins} !== {8'd23, 8'd55} || alarm_enabled !== 4'b1111) begin errors++; $display("FAIL to_keep got %0d:%0d en=%b want 23:55 en=1111", alarm_hours, alarm_mins, alarm_enabled); end
  endtask

  task automatic test_edit_blocks_match();
    press(B_SET, 1); tick(8'd6, 8'd30);
    checks++; if (alarm_ringing !== 1'b0 || editing !== 1'b1) begin errors++; $display("FAIL edit_nomatch got ring=%0b edit=%0b want 0 1", alarm_ringing, editing); end
    press(B_TOG, 1);
    checks++; if (alarm_enabled !== 4'b1111) begin errors++; $display("FAIL tog_ignored got %b want 1111", alarm_enabled); end
    press(B_SET, 2);
    press(B_TOG, 1);
    checks++; if (alarm_enabled !== 4'b1101) begin errors++; $display("FAIL toggle got %b want 1101", alarm_enabled); end
    tick(8'd23, 8'd55);
    checks++; if (alarm_ringing !== 1'b0) begin errors++; $display("FAIL dis_slot got %0b want 0", alarm_ringing); end
  endtask

  task automatic test_wrap();
    press(B_SET, 1); press(B_HR, 1);
    checks++; if (alarm_hours !== 8'd0) begin errors++; $display("FAIL hr_wrap got %0d want 0", alarm_hours); end
    press(B_HR | B_SET, 1); press(B_MIN, 1);
    checks++; if (alarm_hours !== 8'd1 || alarm_mins !== 8'd55) begin errors++; $display("FAIL hr_prio got %0d:%0d want 1:55", alarm_hours, alarm_mins); end
    press(B_SET, 1); press(B_MIN, 5);
    checks++; if (alarm_mins !== 8'd0) begin errors++; $display("FAIL min_wrap got %0d want 0", alarm_mins); end
    press(B_MIN | B_SET, 1);
    checks++; if (alarm_mins !== 8'd1 || editing !== 1'b1) begin errors++; $display("FAIL min_prio got m=%0d edit=%0b want 1 1", alarm_mins, editing); end
    press(B_SET, 1);
    checks++; if (editing !== 1'b0 || alarm_enabled !== 4'b1111) begin errors++; $display("FAIL wrap_exit got edit=%0b en=%b want 0 1111", editing, alarm_enabled); end
  endtask

  task automatic test_reset_ringing();
    tick(8'd1, 8'd1);
    checks++; if (alarm_ringing !== 1'b1 || ring_index !== 2'd1) begin errors++; $display("FAIL ring_0101 got ring=%0b idx=%0d want 1 1", alarm_ringing, ring_index); end
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    checks++; if ({alarm_ringing, alarm_snoozed, editing} !== 3'b000 || ring_index !== 2'd0 || sel_index !== 2'd0) begin errors++; $display("FAIL rst_ring got flags=%b ridx=%0d sel=%0d want 000 0 0", {alarm_ringing, alarm_snoozed, editing}, ring_index, sel_index); end
    checks++; if (alarm_enabled !== 4'b0000 || {alarm_hours, alarm_mins} !== 16'd0) begin errors++; $display("FAIL rst_store got en=%b %0d:%0d want 0000 0:0", alarm_enabled, alarm_hours, alarm_mins); end
  endtask

  initial begin
    test_reset();
    test_set_and_ring();
    test_lowest_index();
    test_snooze();
    test_timeout();
    test_edit_blocks_match();
    test_wrap();
    test_reset_ringing();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alarm_bank_ctrl.md
ALARM_BANK_CTRL -- requirements
Module: alarm_bank_ctrl

Interface
REQ-001 SHALL have parameter NUM_ALARMS, default 4, number of independent alarm slots (legal 2..16).
REQ-002 SHALL have parameter SNOOZE_MINS, default 9, snooze length in minutes (legal 1..59).
REQ-003 SHALL have parameter RING_TIMEOUT_MINS, default 5, minutes of ringing before auto-dismiss (legal 1..59).
REQ-004 SHALL define IW = max(1, clog2(NUM_ALARMS)) as the slot index width.
REQ-005 Ports, clock and reset first:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- btn_set  in  1  one-cycle pulse; enter/advance edit mode.
- btn_sel  in  1  one-cycle pulse; select next slot.
- btn_inc_hours  in  1  one-cycle pulse; increment hours of edited slot.
- btn_inc_mins  in  1  one-cycle pulse; increment minutes of edited slot.
- btn_toggle_en  in  1  one-cycle pulse; toggle enable of selected slot.
- btn_snooze  in  1  one-cycle pulse; snooze ringing alarm.
- btn_dismiss  in  1  one-cycle pulse; stop ringing or snooze.
- current_hours  in  8  binary 0..23.
- current_mins  in  8  binary 0..59.
- min_tick  in  1  one-cycle pulse, asserted on the cycle current_* change to a new minute.
- sel_index  out  IW  selected slot.
- alarm_hours  out  8  stored hours of selected slot.
- alarm_mins  out  8  stored minutes of selected slot.
- alarm_enabled  out  NUM_ALARMS  per-slot enable bits.
- editing  out  1  high in SET_HOURS or SET_MINS.
- alarm_ringing  out  1  high in RINGING.
- alarm_snoozed  out  1  high in SNOOZED.
- ring_index  out  IW  slot that caused current ring/snooze.

Function
REQ-006 States SHALL be IDLE, SET_HOURS, SET_MINS, RINGING, SNOOZED.
REQ-007 IDLE: btn_set -> SET_HOURS; btn_sel -> sel_index+1, wrapping NUM_ALARMS-1 -> 0; btn_toggle_en inverts alarm_enabled[sel_index].
REQ-008 SET_HOURS: btn_inc_hours -> hours of selected slot +1, 23 wraps to 0; btn_set -> SET_MINS; btn_inc_hours takes priority over btn_set in the same cycle.
REQ-009 SET_MINS: btn_inc_mins -> minutes +1, 59 wraps to 0; btn_set -> IDLE and sets alarm_enabled[sel_index]=1; btn_inc_mins takes priority over btn_set.
REQ-010 btn_sel and btn_toggle_en SHALL be ignored outside IDLE.
REQ-011 Match check SHALL occur only on min_tick cycles in IDLE or SNOOZED: slot i matches when enabled and hours/mins equal current_hours/current_mins.
REQ-012 On a match, next state SHALL be RINGING with ring_index = lowest matching index, ring-minute counter cleared; alarm_ringing rises one cycle after the min_tick.
REQ-013 Matches SHALL NOT be evaluated in SET_HOURS, SET_MINS or RINGING; a missed match is not retroactive.
REQ-014 RINGING: btn_dismiss -> IDLE; else btn_snooze -> SNOOZED with snooze target = current time + SNOOZE_MINS modulo 24h (minute carry into hours, 23:xx wraps to 00:xx); dismiss wins over snooze.
REQ-015 RINGING: each min_tick increments ring counter; on reaching RING_TIMEOUT_MINS -> IDLE (auto-dismiss), unless a button acts in the same cycle.
REQ-016 SNOOZED: btn_dismiss -> IDLE; on min_tick with current time equal to snooze target -> RINGING, same ring_index, counter cleared.
REQ-017 SNOOZED: a slot match (REQ-011) in the same min_tick as the snooze target SHALL ring the matching slot's index; a slot match alone cancels the snooze and rings that slot.
REQ-018 Dismiss and timeout SHALL leave stored alarm times and enables unchanged.
REQ-019 btn_set in RINGING or SNOOZED SHALL be ignored.
REQ-020 alarm_hours/alarm_mins SHALL always reflect the slot at sel_index, combinationally.

Reset
REQ-021 reset high at a rising edge SHALL force state IDLE, sel_index=0, ring_index=0, all alarm times 00:00, alarm_enabled=0, snooze target 00:00, ring counter 0, all outputs low/zero, regardless of state or other inputs.
REQ-022 Reset asserted mid-RINGING or mid-edit SHALL abandon the operation with no partial output next cycle.

Verification
REQ-023 Set slot 2 to 06:30 (sel x2, set, inc_hours x6, set, inc_mins x30, set); min_tick at 06:30 -> alarm_ringing=1, ring_index=2 next cycle.
REQ-024 Slots 0 and 3 both 07:00 enabled; min_tick at 07:00 -> ring_index=0.
REQ-025 Ringing at 23:55, btn_snooze -> alarm_snoozed=1; min_tick at 00:04 -> alarm_ringing=1, same ring_index.
REQ-026 Ring with no buttons, 5 min_ticks -> return to IDLE on 5th, times/enables unchanged.
REQ-027 btn_snooze and btn_dismiss same cycle while ringing -> IDLE, alarm_snoozed=0.
REQ-028 Hours 23 + inc -> 0; minutes 59 + inc -> 0; reset while ringing -> all outputs zero next cycle.
